// File: rtl/dmem_block_memory.sv
// Block-granular data memory behind the data-cache controller: whole-block fills and
// writebacks with fixed latencies and a one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for a read or write strobe
// READ  | fill in progress, counting down
// WRITE | writeback in progress, counting down
// DONE  | completion pulse cycle; strobes ignored
module dmem_block_memory #(
    parameter int ADDR_W     = 8,
    parameter int BLOCK_BITS = 128,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memRen,
    input  logic                  memWen,
    input  logic [ADDR_W-1:0]     BlockAddr,
    input  logic [BLOCK_BITS-1:0] memDin,
    output logic [BLOCK_BITS-1:0] memDout,
    output logic                  memReadReady,
    output logic                  memWriteDone,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] RD_LAT = 8'(READ_LAT);
    localparam logic [7:0] WR_LAT = 8'(WRITE_LAT);

    logic [1:0]            state;
    logic [7:0]            cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [BLOCK_BITS-1:0] din_q;
    logic [BLOCK_BITS-1:0] mem_array [0:(1<<ADDR_W)-1];

    logic                  accept_rd;
    logic                  accept_wr;
    logic                  rd_now;
    logic                  wr_now;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     wr_addr;
    logic [BLOCK_BITS-1:0] wr_data;

    assign accept_rd = (state == ST_IDLE) && memRen && !memWen;
    assign accept_wr = (state == ST_IDLE) && memWen && !memRen;

    // The pulse must be visible in cycle LAT counting the acceptance cycle as 0, so the
    // completing edge is the one taking cnt from 2 to 1; a latency of 1 completes at acceptance.
    assign rd_now = (accept_rd && (RD_LAT == 8'd1)) ||
                    ((state == ST_READ) && memRen && (cnt == 8'd2));
    assign wr_now = reset && ((accept_wr && (WR_LAT == 8'd1)) ||
                    ((state == ST_WRITE) && memWen && (cnt == 8'd2)));

    assign rd_addr = (state == ST_IDLE) ? BlockAddr : addr_q;
    assign wr_addr = (state == ST_IDLE) ? BlockAddr : addr_q;
    assign wr_data = (state == ST_IDLE) ? memDin : din_q;

    assign busy = (state != ST_IDLE);

    // Array contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_now) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            addr_q       <= '0;
            din_q        <= '0;
            memDout      <= '0;
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
            err          <= 1'b0;
        end else begin
            memReadReady <= 1'b0;
            memWriteDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (memRen && memWen) begin
                        err <= 1'b1;
                    end else if (memRen) begin
                        addr_q <= BlockAddr;
                        cnt    <= RD_LAT;
                        state  <= (RD_LAT == 8'd1) ? ST_DONE : ST_READ;
                    end else if (memWen) begin
                        addr_q <= BlockAddr;
                        din_q  <= memDin;
                        cnt    <= WR_LAT;
                        state  <= (WR_LAT == 8'd1) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (!memRen) begin
                        state <= ST_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd2) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!memWen) begin
                        state <= ST_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd2) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
            if (rd_now) begin
                memDout      <= mem_array[rd_addr];
                memReadReady <= 1'b1;
            end
            if (wr_now) begin
                memWriteDone <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_block_memory.sv
// Directed bench for dmem_block_memory: latencies, hold behaviour, writeback-fill,
// strobe-through-DONE, abort, error and mid-operation reset.
module tb_dmem_block_memory;

    localparam int ADDR_W = 8;
    localparam int BB     = 128;
    localparam int RL     = 4;
    localparam int WL     = 4;

    localparam logic [BB-1:0] DATA_X = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [BB-1:0] DATA_A = 128'hA5A5_A5A5_1111_2222_3333_4444_5A5A_5A5A;
    localparam logic [BB-1:0] DATA_B = 128'hBBBB_0000_BBBB_0000_BBBB_0000_BBBB_0000;
    localparam logic [BB-1:0] DATA_C = 128'hC0DE_CAFE_0000_FFFF_1234_5678_9ABC_DEF0;

    logic              clock = 1'b0;
    logic              reset;
    logic              memRen;
    logic              memWen;
    logic [ADDR_W-1:0] BlockAddr;
    logic [BB-1:0]     memDin;
    logic [BB-1:0]     memDout;
    logic              memReadReady;
    logic              memWriteDone;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    dmem_block_memory #(
        .ADDR_W(ADDR_W), .BLOCK_BITS(BB), .READ_LAT(RL), .WRITE_LAT(WL)
    ) dut (
        .clock(clock), .reset(reset), .memRen(memRen), .memWen(memWen),
        .BlockAddr(BlockAddr), .memDin(memDin), .memDout(memDout),
        .memReadReady(memReadReady), .memWriteDone(memWriteDone),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (memReadReady) rd_pulses <= rd_pulses + 1;
        if (memWriteDone) wr_pulses <= wr_pulses + 1;
    end

    task automatic chk(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in cycle 0, holds the strobe through the pulse cycle, returns one cycle later
    // with both strobes low.
    task automatic run_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [BB-1:0] d,
                          output int lat);
        memWen    = wr;
        memRen    = !wr;
        BlockAddr = a;
        memDin    = d;
        lat       = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick();
            if (wr ? memWriteDone : memReadReady) lat = c;
        end
        tick();
        memWen = 1'b0;
        memRen = 1'b0;
    endtask

    initial begin
        int lat_w;
        int lat_r;
        int rp0;
        int wp0;
        int c;
        logic got_ready;

        reset     = 1'b0;
        memRen    = 1'b1;
        memWen    = 1'b1;
        BlockAddr = '0;
        memDin    = '0;
        tick(); tick(); tick();
        chk("rst_ready", BB'(memReadReady), '0);
        chk("rst_done", BB'(memWriteDone), '0);
        chk("rst_dout", memDout, '0);
        chk("rst_busy", BB'(busy), '0);
        chk("rst_err", BB'(err), '0);
        memRen = 1'b0;
        memWen = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_ready", BB'(rd_pulses), '0);

        // Write then read at 0x12
        wp0 = wr_pulses;
        run_op(1'b1, 8'h12, DATA_X, lat_w);
        chk("wr_lat", BB'(lat_w), BB'(WL));
        chk("wr_one_pulse", BB'(wr_pulses - wp0), BB'(1));
        rp0 = rd_pulses;
        run_op(1'b0, 8'h12, '0, lat_r);
        chk("rd_lat", BB'(lat_r), BB'(RL));
        chk("rd_data", memDout, DATA_X);
        for (int i = 0; i < 10; i++) tick();
        chk("rd_hold", memDout, DATA_X);
        chk("rd_one_pulse", BB'(rd_pulses - rp0), BB'(1));

        // Writeback immediately followed by fill
        rp0 = rd_pulses;
        wp0 = wr_pulses;
        run_op(1'b1, 8'h05, DATA_A, lat_w);
        run_op(1'b0, 8'h05, '0, lat_r);
        chk("wbf_turnaround", BB'(lat_w + 1 + lat_r), BB'(WL + RL + 1));
        chk("wbf_data", memDout, DATA_A);
        chk("wbf_rd_pulses", BB'(rd_pulses - rp0), BB'(1));
        chk("wbf_wr_pulses", BB'(wr_pulses - wp0), BB'(1));

        // Strobe held through DONE re-arms on the first IDLE cycle
        rp0 = rd_pulses;
        memRen    = 1'b1;
        BlockAddr = 8'h12;
        got_ready = 1'b0;
        c = 0;
        while (!got_ready && c < 20) begin
            tick();
            c++;
            got_ready = memReadReady;
        end
        chk("held_lat", BB'(c), BB'(RL));
        tick();
        chk("held_idle_ready", BB'(memReadReady), '0);
        chk("held_idle_busy", BB'(busy), '0);
        tick();
        chk("held_second_busy", BB'(busy), BB'(1));
        tick();
        tick();
        memRen = 1'b0;
        tick(); tick(); tick(); tick();
        chk("held_abort_busy", BB'(busy), '0);
        chk("held_rd_pulses", BB'(rd_pulses - rp0), BB'(1));
        chk("held_dout", memDout, DATA_X);

        // Write abort leaves the array and memDout untouched
        run_op(1'b1, 8'h20, DATA_C, lat_w);
        chk("pre_abort_wr_lat", BB'(lat_w), BB'(WL));
        chk("wr_keeps_dout", memDout, DATA_X);
        wp0 = wr_pulses;
        memWen    = 1'b1;
        BlockAddr = 8'h20;
        memDin    = DATA_B;
        tick(); tick();
        memWen = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_no_pulse", BB'(wr_pulses - wp0), '0);
        chk("abort_dout", memDout, DATA_X);
        run_op(1'b0, 8'h20, '0, lat_r);
        chk("abort_readback", memDout, DATA_C);

        // Both strobes together in IDLE
        rp0 = rd_pulses;
        wp0 = wr_pulses;
        memRen = 1'b1;
        memWen = 1'b1;
        tick();
        chk("err_set", BB'(err), BB'(1));
        memRen = 1'b0;
        memWen = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("err_sticky", BB'(err), BB'(1));
        chk("err_no_pulse", BB'((rd_pulses - rp0) + (wr_pulses - wp0)), '0);

        // Reset in the middle of a read
        rp0 = rd_pulses;
        memRen    = 1'b1;
        BlockAddr = 8'h12;
        tick(); tick();
        chk("midop_busy", BB'(busy), BB'(1));
        reset = 1'b0;
        #1;
        chk("midop_dout", memDout, '0);
        chk("midop_busy_rst", BB'(busy), '0);
        chk("midop_err_rst", BB'(err), '0);
        tick();
        memRen = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("midop_no_pulse", BB'(rd_pulses - rp0), '0);
        chk("midop_dout_after", memDout, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
